adc_averager: RTL and testbench
===============================

ADC_AVERAGER -- requirements
Module: adc_averager

Interface
REQ-001 SAMPLE_PERIOD, 480, clk cycles between successive read requests (>= 64).
REQ-002 AVG_LOG2, 3, log2 of samples per average (1..6).
REQ-003 TIMEOUT_CYCLES, 256, clk cycles allowed from read assertion to read_done edge.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  level; 1 = run periodic sampling.
REQ-007 adc_value  input  12  sample from the ADC stage, stable while adc_read_done high.
REQ-008 adc_read_done  input  1  ADC completion flag, from the sclk domain, asynchronous to clk.
REQ-009 limit  input  12  over-limit threshold, compared against each average.
REQ-010 adc_read  output  1  read request level to the ADC stage.
REQ-011 avg_value  output  12  latest average.
REQ-012 avg_valid  output  1  one-cycle pulse on each new avg_value.
REQ-013 over_limit  output  1  1 when latest avg_value > limit.
REQ-014 timeout  output  1  sticky; set on any request timeout.

Function
REQ-015 adc_read_done SHALL pass through a 2-flop synchronizer; done_edge = synced 0->1 transition, 1 clk wide.
REQ-016 Period counter SHALL count 0..SAMPLE_PERIOD-1 while enable=1, wrap to 0, and produce tick at SAMPLE_PERIOD-1; held at 0 while enable=0.
REQ-017 States: IDLE, REQUEST, ACCUM, OUTPUT; reset state IDLE.
REQ-018 IDLE -> REQUEST on tick when synced read_done=0; tick while synced read_done=1 is dropped, no request.
REQ-019 REQUEST: adc_read=1 every cycle; on done_edge capture adc_value -> ACCUM; adc_read=0 from the following cycle.
REQ-020 REQUEST: timeout counter exceeding TIMEOUT_CYCLES-1 without done_edge SHALL set timeout, drop adc_read, return to IDLE, leave accumulator and sample count unchanged.
REQ-021 ACCUM (1 cycle): acc += captured sample; cnt += 1; -> OUTPUT if cnt reached 2^AVG_LOG2, else IDLE.
REQ-022 Accumulator width SHALL be 12+AVG_LOG2 bits; no overflow possible; sum of 2^AVG_LOG2 samples of 4095 fits exactly.
REQ-023 OUTPUT (1 cycle): avg_value = acc >> AVG_LOG2 (truncating); avg_valid=1; over_limit = (avg > limit), unsigned; acc, cnt cleared; -> IDLE.
REQ-024 enable=0 in REQUEST SHALL NOT abort the request; block completes it, then stays IDLE. Partial accumulation SHALL be retained across enable toggles.
REQ-025 done_edge outside REQUEST SHALL be ignored.
REQ-026 Tick arriving in REQUEST/ACCUM/OUTPUT SHALL be dropped (no queuing).
REQ-027 Simultaneous done_edge and timeout expiry in the same cycle: done_edge wins; timeout not set.
REQ-028 timeout SHALL clear only on reset.
REQ-029 Request latency: adc_read rises 1 clk after tick.

Reset
REQ-030 reset=0 SHALL immediately force: state IDLE, adc_read=0, avg_value=0, avg_valid=0, over_limit=0, timeout=0, acc=0, cnt=0, period/timeout counters=0, synchronizer flops=0.
REQ-031 Reset asserted mid-REQUEST SHALL drop adc_read asynchronously and discard the pending sample.
REQ-032 After reset release, first tick occurs SAMPLE_PERIOD cycles after enable first seen 1.

Verification
REQ-033 AVG_LOG2=2, ADC model returns 100,200,300,400 -> one avg_valid pulse, avg_value=250, over_limit=0 with limit=300.
REQ-034 Same with samples 4095x4 and limit=4094 -> avg_value=4095, over_limit=1.
REQ-035 ADC model never raises read_done, TIMEOUT_CYCLES=64 -> adc_read high for 64 cycles, then 0; timeout=1 and stays 1; cnt unchanged.
REQ-036 reset=0 while adc_read=1 -> adc_read=0 same cycle; subsequent 4 samples of 10 produce avg_value=10 (no stale data).
REQ-037 read_done held high across tick -> no adc_read pulse for that period; next period requests normally.
REQ-038 enable dropped after 2 of 4 samples, re-raised -> 2 more samples complete the average, single avg_valid.

Source files
------------

// File: rtl/adc_averager.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : adc_averager
// Description : Periodically requests a sample from an external ADC stage,
//               accumulates 2^AVG_LOG2 samples and publishes their truncated
//               mean, together with an over-limit flag and a sticky request
//               timeout flag.
// Ports       : clk           - system clock, rising edge
//               reset         - asynchronous active-low reset
//               enable        - 1 = run periodic sampling
//               adc_value     - 12-bit sample, stable while adc_read_done is high
//               adc_read_done - ADC completion flag (asynchronous to clk)
//               limit         - 12-bit over-limit threshold
//               adc_read      - read request level to the ADC stage
//               avg_value     - latest average
//               avg_valid     - one-cycle pulse per new avg_value
//               over_limit    - 1 when latest avg_value > limit
//               timeout       - sticky request timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module adc_averager #(
  parameter int SAMPLE_PERIOD  = 480,
  parameter int AVG_LOG2       = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] adc_value,
  input  logic        adc_read_done,
  input  logic [11:0] limit,
  output logic        adc_read,
  output logic [11:0] avg_value,
  output logic        avg_valid,
  output logic        over_limit,
  output logic        timeout
);

  localparam int ACC_W  = 12 + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int PCNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [PCNT_W-1:0] PERIOD_LAST  = PCNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL     = CNT_W'(1 << AVG_LOG2);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_ACCUM   = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_t;

  state_t              state_q,      state_d;
  logic                sync1_q,      sync2_q,      sync3_q;
  logic [PCNT_W-1:0]   pcnt_q,       pcnt_d;
  logic [TCNT_W-1:0]   tcnt_q,       tcnt_d;
  logic [ACC_W-1:0]    acc_q,        acc_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic [11:0]         sample_q,     sample_d;
  logic [11:0]         avg_value_q,  avg_value_d;
  logic                avg_valid_q,  avg_valid_d;
  logic                over_limit_q, over_limit_d;
  logic                timeout_q,    timeout_d;

  logic                done_edge;
  logic                tick;
  logic [ACC_W-1:0]    acc_sum;
  logic [CNT_W-1:0]    cnt_inc;
  logic [11:0]         acc_mean;

  // Two-flop synchronizer; the third flop only exists to detect the rising
  // edge of the already-synchronized flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= adc_read_done;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  always_comb begin
    done_edge = sync2_q & ~sync3_q;
    tick      = enable && (pcnt_q == PERIOD_LAST);
    acc_sum   = acc_q + ACC_W'(sample_q);
    cnt_inc   = cnt_q + CNT_W'(1);
    // Truncating divide by 2^AVG_LOG2; the accumulator is sized so the
    // quotient always fits in 12 bits.
    acc_mean  = acc_q[ACC_W-1:AVG_LOG2];
  end

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    sample_d     = sample_q;
    avg_value_d  = avg_value_q;
    avg_valid_d  = 1'b0;
    over_limit_d = over_limit_q;
    timeout_d    = timeout_q;

    // Period counter restarts from zero whenever sampling is disabled, so the
    // first tick after enabling lands a full period later.
    if (!enable) begin
      pcnt_d = '0;
    end else if (pcnt_q == PERIOD_LAST) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PCNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        // A tick while the ADC still shows done high is skipped: the stage
        // has not returned to idle, so a new request would be ambiguous.
        if (tick && !sync2_q) begin
          state_d = ST_REQUEST;
          tcnt_d  = '0;
        end
      end

      ST_REQUEST: begin
        // done_edge is checked first so it wins over a coincident expiry.
        // adc_value is safe to sample here: it is held stable while the
        // ADC's done flag is high, which covers the synchronizer delay.
        if (done_edge) begin
          sample_d = adc_value;
          state_d  = ST_ACCUM;
        end else if (tcnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      ST_ACCUM: begin
        acc_d = acc_sum;
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_FULL) begin
          state_d = ST_OUTPUT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_OUTPUT: begin
        avg_value_d  = acc_mean;
        avg_valid_d  = 1'b1;
        over_limit_d = (acc_mean > limit);
        acc_d        = '0;
        cnt_d        = '0;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pcnt_q       <= '0;
      tcnt_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      sample_q     <= '0;
      avg_value_q  <= '0;
      avg_valid_q  <= 1'b0;
      over_limit_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      tcnt_q       <= tcnt_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      sample_q     <= sample_d;
      avg_value_q  <= avg_value_d;
      avg_valid_q  <= avg_valid_d;
      over_limit_q <= over_limit_d;
      timeout_q    <= timeout_d;
    end
  end

  // Decoded straight from the state register so an asynchronous reset drops
  // the request immediately rather than at the next clock.
  assign adc_read   = (state_q == ST_REQUEST);
  assign avg_value  = avg_value_q;
  assign avg_valid  = avg_valid_q;
  assign over_limit = over_limit_q;
  assign timeout    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_averager.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_adc_averager
// Description : Self-checking bench for adc_averager with a behavioural ADC
//               model and a scoreboard of expected averages.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_averager;

  localparam int SAMPLE_PERIOD  = 64;
  localparam int AVG_LOG2       = 2;
  localparam int TIMEOUT_CYCLES = 64;

  typedef struct {
    logic [11:0] val;
    logic        ovl;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] adc_value;
  logic        done_model;
  logic        force_done;
  wire         adc_read_done = done_model | force_done;
  logic [11:0] limit;
  logic        adc_read;
  logic [11:0] avg_value;
  logic        avg_valid;
  logic        over_limit;
  logic        timeout;

  int          vectors     = 0;
  int          miscompares = 0;
  int          valid_pulses = 0;
  logic        model_busy;

  logic [11:0] samp_q[$];
  exp_t        exp_q[$];

  adc_averager #(
    .SAMPLE_PERIOD (SAMPLE_PERIOD),
    .AVG_LOG2      (AVG_LOG2),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .adc_value    (adc_value),
    .adc_read_done(adc_read_done),
    .limit        (limit),
    .adc_read     (adc_read),
    .avg_value    (avg_value),
    .avg_valid    (avg_valid),
    .over_limit   (over_limit),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  // ADC model: answers a request only when a sample is queued, holds done
  // high until the request is withdrawn, then returns to idle.
  initial begin
    done_model = 1'b0;
    adc_value  = '0;
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (adc_read && samp_q.size() > 0) begin
        model_busy = 1'b1;
        repeat (3) @(negedge clk);
        adc_value  = samp_q.pop_front();
        done_model = 1'b1;
        for (int i = 0; i < 40 && adc_read; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        done_model = 1'b0;
        repeat (2) @(negedge clk);
        model_busy = 1'b0;
      end
    end
  end

  // Scoreboard consumer: every avg_valid pulse pops one expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (avg_valid) begin
        valid_pulses++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_avg: got avg_value=%0d over_limit=%0b, required no output",
                   avg_value, over_limit);
        end else begin
          e = exp_q.pop_front();
          if (avg_value !== e.val || over_limit !== e.ovl) begin
            miscompares++;
            $display("FAIL avg_result: got avg_value=%0d over_limit=%0b, required avg_value=%0d over_limit=%0b",
                     avg_value, over_limit, e.val, e.ovl);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [11:0] v, input logic o);
    exp_t e;
    e.val = v;
    e.ovl = o;
    exp_q.push_back(e);
  endtask

  task automatic go_idle();
    enable = 1'b0;
    for (int i = 0; i < 200 && (adc_read || model_busy); i++) @(negedge clk);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; force_done = 1'b0; limit = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({adc_read, avg_value, avg_valid, over_limit, timeout} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rd=%0b avg=%0d vld=%0b ovl=%0b to=%0b, required all 0",
               adc_read, avg_value, avg_valid, over_limit, timeout);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_average(input string name, input logic [11:0] s0, input logic [11:0] s1,
                              input logic [11:0] s2, input logic [11:0] s3,
                              input logic [11:0] lim);
    int          start;
    int          sum;
    logic [11:0] avg;
    start = valid_pulses;
    limit = lim;
    sum   = int'(s0) + int'(s1) + int'(s2) + int'(s3);
    avg   = 12'(sum / 4);
    push_exp(avg, avg > lim);
    samp_q.push_back(s0); samp_q.push_back(s1); samp_q.push_back(s2); samp_q.push_back(s3);
    enable = 1'b1;
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d results pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    vectors++;
    if (valid_pulses - start != 1) begin
      miscompares++;
      $display("FAIL %s_pulses: got %0d avg_valid pulses, required 1", name, valid_pulses - start);
    end
    go_idle();
  endtask

  task automatic test_read_done_high();
    int hi;
    int start;
    start = valid_pulses;
    limit = 12'd1;
    force_done = 1'b1;
    enable = 1'b1;
    hi = 0;
    repeat (80) begin
      @(negedge clk);
      if (adc_read) hi++;
    end
    vectors++;
    if (hi != 0) begin
      miscompares++;
      $display("FAIL done_high_no_request: got %0d adc_read cycles, required 0", hi);
    end
    force_done = 1'b0;
    // (1+2+3+4)/4 truncates to 2
    push_exp(12'd2, 1'b1);
    samp_q.push_back(12'd1); samp_q.push_back(12'd2);
    samp_q.push_back(12'd3); samp_q.push_back(12'd4);
    hi = 0;
    for (int i = 0; i < 80 && !adc_read; i++) @(negedge clk);
    vectors++;
    if (adc_read !== 1'b1) begin
      miscompares++;
      $display("FAIL done_high_next_period: got adc_read=%0b, required 1", adc_read);
    end
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0 || valid_pulses - start != 1) begin
      miscompares++;
      $display("FAIL done_high_avg: got %0d pending %0d pulses, required 0 pending 1 pulse",
               exp_q.size(), valid_pulses - start);
      exp_q.delete();
    end
    go_idle();
  endtask

  task automatic test_enable_toggle();
    int hi;
    int start;
    start = valid_pulses;
    limit = 12'd20;
    push_exp(12'd20, 1'b0);
    samp_q.push_back(12'd8); samp_q.push_back(12'd16);
    enable = 1'b1;
    for (int i = 0; i < 400 && samp_q.size() != 0; i++) @(negedge clk);
    // second request is in flight: disabling must not abort it
    enable = 1'b0;
    for (int i = 0; i < 100 && model_busy; i++) @(negedge clk);
    hi = 0;
    repeat (200) begin
      @(negedge clk);
      if (adc_read) hi++;
    end
    vectors++;
    if (hi != 0 || valid_pulses != start) begin
      miscompares++;
      $display("FAIL enable_off_quiet: got %0d read cycles %0d pulses, required 0 and 0",
               hi, valid_pulses - start);
    end
    samp_q.push_back(12'd24); samp_q.push_back(12'd32);
    enable = 1'b1;
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0 || valid_pulses - start != 1) begin
      miscompares++;
      $display("FAIL enable_toggle_avg: got %0d pending %0d pulses, required 0 pending 1 pulse",
               exp_q.size(), valid_pulses - start);
      exp_q.delete();
    end
    go_idle();
  endtask

  task automatic test_timeout();
    int hi;
    limit = 12'd49;
    push_exp(12'd50, 1'b1);
    samp_q.push_back(12'd20); samp_q.push_back(12'd40);
    enable = 1'b1;
    for (int i = 0; i < 400 && (samp_q.size() != 0 || model_busy); i++) @(negedge clk);
    vectors++;
    if (timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: got timeout=%0b, required 0", timeout);
    end
    for (int i = 0; i < 200 && !adc_read; i++) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 200 && adc_read; i++) begin
      hi++;
      @(negedge clk);
    end
    vectors++;
    if (hi != TIMEOUT_CYCLES) begin
      miscompares++;
      $display("FAIL timeout_read_width: got %0d adc_read cycles, required %0d", hi, TIMEOUT_CYCLES);
    end
    vectors++;
    if (timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_set: got timeout=%0b, required 1", timeout);
    end
    // partial count must survive the timeout: two more samples finish the set
    samp_q.push_back(12'd60); samp_q.push_back(12'd80);
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL timeout_count_kept: got %0d results pending, required 0", exp_q.size());
      exp_q.delete();
    end
    vectors++;
    if (timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_sticky: got timeout=%0b, required 1", timeout);
    end
    go_idle();
  endtask

  task automatic test_reset_mid_request();
    int start;
    samp_q.delete();
    enable = 1'b1;
    for (int i = 0; i < 200 && !adc_read; i++) @(negedge clk);
    vectors++;
    if (adc_read !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_setup: got adc_read=%0b, required 1", adc_read);
    end
    #3;
    reset = 1'b0;
    #1;
    vectors++;
    if (adc_read !== 1'b0 || timeout !== 1'b0 || avg_value !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_async: got rd=%0b to=%0b avg=%0d, required 0 0 0",
               adc_read, timeout, avg_value);
    end
    @(negedge clk);
    reset = 1'b1;
    start = valid_pulses;
    limit = 12'd9;
    push_exp(12'd10, 1'b1);
    repeat (4) samp_q.push_back(12'd10);
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0 || valid_pulses - start != 1) begin
      miscompares++;
      $display("FAIL reset_fresh_avg: got %0d pending %0d pulses, required 0 pending 1 pulse",
               exp_q.size(), valid_pulses - start);
      exp_q.delete();
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_average("basic",      12'd100,  12'd200,  12'd300,  12'd400,  12'd300);
    test_average("full_scale", 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4094);
    test_read_done_high();
    test_enable_toggle();
    test_timeout();
    test_reset_mid_request();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
